// File: rtl/example1_pkg.sv
// -----------------------------------------------------------------------------
// example1_pkg
// Shared definitions for the Example1 driver slice: value and count widths,
// default scoreboard depth and watchdog limit, the driver FSM state encoding
// and a saturating counter helper.
// No ports (package).
// -----------------------------------------------------------------------------
package example1_pkg;

    // Width of every say/heard value.
    localparam int VALUE_W = 32;

    // Width of the request count and of the error counter.
    localparam int COUNT_W = 16;

    // Default number of outstanding say requests (power of 2, 2..16).
    localparam int DEPTH_DEFAULT = 4;

    // Default number of silent cycles before a run is aborted.
    localparam int TIMEOUT_DEFAULT = 1024;

    // Driver FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] val);
        logic [COUNT_W-1:0] res;
        if (val == {COUNT_W{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/example1_scoreboard_fifo.sv
// -----------------------------------------------------------------------------
// example1_scoreboard_fifo
// DEPTH x WIDTH synchronous FIFO holding the say values still waiting for
// their heard response. Pointers wrap naturally (DEPTH is a power of 2) and
// an occupancy counter distinguishes full from empty.
//
// Ports:
//   CLK       in   clock, rising edge
//   nRST      in   synchronous active-low reset (empties the FIFO)
//   flush     in   drop all entries (takes priority over push/pop)
//   push      in   write push_data; ignored when full before this cycle
//   push_data in   value to store
//   pop       in   discard head; ignored when empty
//   full      out  occupancy == DEPTH
//   empty     out  occupancy == 0
//   head      out  oldest stored value (valid when !empty)
// -----------------------------------------------------------------------------
module example1_scoreboard_fifo
    import example1_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = VALUE_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify push/pop against the occupancy at the start of the cycle.
    always_comb begin
        push_ok_s = push && (count_r != CNT_FULL);
        pop_ok_s  = pop && (count_r != {(AW + 1){1'b0}});
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because head is only consumed when non-empty.
    always_ff @(posedge CLK) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Status and head decode from registered state only.
    always_comb begin
        full  = (count_r == CNT_FULL);
        empty = (count_r == {(AW + 1){1'b0}});
        head  = mem_r[rd_ptr_r];
    end

endmodule

// File: rtl/example1_driver.sv
// -----------------------------------------------------------------------------
// example1_driver
// Drives a run of consecutive say requests to a responder, checks every heard
// value against the value that was said (in order), and reports the mismatch
// count and a watchdog abort flag to the host.
//
// Ports:
//   CLK, nRST                    clock and synchronous active-low reset
//   start__ENA/__RDY             host starts a run (start_base, start_count)
//   request_say__ENA/__RDY       say request carrying request_say_v
//   indication_heard__ENA/__RDY  responder returns indication_heard_v
//   done__ENA/__RDY              run report (done_errors, done_timeout)
// A method transfers in a cycle where its __ENA and __RDY are both 1.
// -----------------------------------------------------------------------------
module example1_driver
    import example1_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               start__ENA,
    input  logic [VALUE_W-1:0] start_base,
    input  logic [COUNT_W-1:0] start_count,
    output logic               start__RDY,
    output logic               request_say__ENA,
    output logic [VALUE_W-1:0] request_say_v,
    input  logic               request_say__RDY,
    input  logic               indication_heard__ENA,
    input  logic [VALUE_W-1:0] indication_heard_v,
    output logic               indication_heard__RDY,
    output logic               done__ENA,
    output logic [COUNT_W-1:0] done_errors,
    output logic               done_timeout,
    input  logic               done__RDY
);

    localparam int                WD_W     = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_ONE   = WD_W'(1);
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
    localparam logic [VALUE_W-1:0] VAL_ONE = VALUE_W'(1);

    state_e             state_r;
    state_e             state_nxt_s;
    logic [VALUE_W-1:0] next_v_r;
    logic [COUNT_W-1:0] remaining_r;
    logic [COUNT_W-1:0] errors_r;
    logic               timeout_r;
    logic [WD_W-1:0]    wd_r;

    logic               active_s;
    logic               start_fire_s;
    logic               say_ena_s;
    logic               say_fire_s;
    logic               heard_rdy_s;
    logic               heard_fire_s;
    logic               done_fire_s;
    logic               mismatch_s;
    logic               wd_count_s;
    logic               wd_hit_s;

    logic               sb_full_s;
    logic               sb_empty_s;
    logic [VALUE_W-1:0] sb_head_s;

    // Outstanding say values, oldest first; emptied on the done transfer.
    example1_scoreboard_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (VALUE_W)
    ) u_scoreboard (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (done_fire_s),
        .push      (say_fire_s),
        .push_data (next_v_r),
        .pop       (heard_fire_s),
        .full      (sb_full_s),
        .empty     (sb_empty_s),
        .head      (sb_head_s)
    );

    // Handshake qualification and watchdog conditions.
    always_comb begin
        active_s     = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
        start_fire_s = (state_r == ST_IDLE) && start__ENA;
        // A full scoreboard blocks the say even if a heard pops this cycle.
        say_ena_s    = (state_r == ST_ISSUE) && (remaining_r != {COUNT_W{1'b0}}) && !sb_full_s;
        say_fire_s   = say_ena_s && request_say__RDY;
        heard_rdy_s  = active_s && !sb_empty_s;
        heard_fire_s = heard_rdy_s && indication_heard__ENA;
        done_fire_s  = (state_r == ST_REPORT) && done__RDY;
        mismatch_s   = (indication_heard_v != sb_head_s);
        wd_count_s   = active_s && !sb_empty_s && !heard_fire_s;
        wd_hit_s     = wd_count_s && (wd_r == WD_LIMIT);
    end

    // Next-state selection; the watchdog abort overrides normal progress.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_fire_s) begin
                    if (start_count == {COUNT_W{1'b0}}) begin
                        state_nxt_s = ST_REPORT;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (wd_hit_s) begin
                    state_nxt_s = ST_REPORT;
                end else if (say_fire_s && (remaining_r == CNT_ONE)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                // Leaves one cycle after the last heard empties the scoreboard.
                if (wd_hit_s || sb_empty_s) begin
                    state_nxt_s = ST_REPORT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_REPORT: begin
                if (done_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REPORT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, run counters, error count and watchdog registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r     <= ST_IDLE;
            next_v_r    <= {VALUE_W{1'b0}};
            remaining_r <= {COUNT_W{1'b0}};
            errors_r    <= {COUNT_W{1'b0}};
            timeout_r   <= 1'b0;
            wd_r        <= {WD_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;

            if (start_fire_s) begin
                next_v_r    <= start_base;
                remaining_r <= start_count;
            end else if (say_fire_s) begin
                next_v_r    <= next_v_r + VAL_ONE;
                remaining_r <= remaining_r - CNT_ONE;
            end else begin
                next_v_r    <= next_v_r;
                remaining_r <= remaining_r;
            end

            if (start_fire_s) begin
                errors_r <= {COUNT_W{1'b0}};
            end else if (heard_fire_s && mismatch_s) begin
                errors_r <= sat_inc(errors_r);
            end else begin
                errors_r <= errors_r;
            end

            if (start_fire_s) begin
                timeout_r <= 1'b0;
            end else if (wd_hit_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end

            // Counts silent cycles with work outstanding; any heard or an empty scoreboard clears it.
            if (wd_count_s && !wd_hit_s) begin
                wd_r <= wd_r + WD_ONE;
            end else begin
                wd_r <= {WD_W{1'b0}};
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        start__RDY            = (state_r == ST_IDLE);
        request_say__ENA      = say_ena_s;
        request_say_v         = next_v_r;
        indication_heard__RDY = heard_rdy_s;
        done__ENA             = (state_r == ST_REPORT);
        done_errors           = errors_r;
        done_timeout          = timeout_r;
    end

endmodule

// File: tb/tb_example1_driver.sv
module tb_example1_driver;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int M_ECHO    = 0;
    localparam int M_CORRUPT = 1;
    localparam int M_HOLD    = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start__ENA;
    logic [31:0] start_base;
    logic [15:0] start_count;
    logic        start__RDY;
    logic        request_say__ENA;
    logic [31:0] request_say_v;
    logic        request_say__RDY;
    logic        indication_heard__ENA;
    logic [31:0] indication_heard_v;
    logic        indication_heard__RDY;
    logic        done__ENA;
    logic [15:0] done_errors;
    logic        done_timeout;
    logic        done__RDY;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    example1_driver #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .start__ENA            (start__ENA),
        .start_base            (start_base),
        .start_count           (start_count),
        .start__RDY            (start__RDY),
        .request_say__ENA      (request_say__ENA),
        .request_say_v         (request_say_v),
        .request_say__RDY      (request_say__RDY),
        .indication_heard__ENA (indication_heard__ENA),
        .indication_heard_v    (indication_heard_v),
        .indication_heard__RDY (indication_heard__RDY),
        .done__ENA             (done__ENA),
        .done_errors           (done_errors),
        .done_timeout          (done_timeout),
        .done__RDY             (done__RDY)
    );

    task automatic test_reset();
        nRST = 1'b0;
        start__ENA = 1'b0;
        start_base = 32'd0;
        start_count = 16'd0;
        request_say__RDY = 1'b0;
        indication_heard__ENA = 1'b0;
        indication_heard_v = 32'd0;
        done__RDY = 1'b0;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        tests_run++;
        if ({start__RDY, request_say__ENA, request_say_v, indication_heard__RDY,
             done__ENA, done_errors, done_timeout} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b say=%b v=%h hrdy=%b done=%b err=%h to=%b, expected rdy=1 others 0",
                     start__RDY, request_say__ENA, request_say_v, indication_heard__RDY,
                     done__ENA, done_errors, done_timeout);
        end
    endtask

    // One complete run: expected says and the expected report are queued at start,
    // then popped as the DUT produces say and done transfers.
    task automatic run_session(input logic [31:0] base, input logic [15:0] count, input int mode,
                               input logic [15:0] exp_err, input logic exp_to, input int exp_says,
                               input string name);
        logic [31:0] say_q[$];
        logic [31:0] resp_q[$];
        logic [16:0] done_q[$];
        logic [16:0] exp_done;
        logic [16:0] got_done;
        logic [31:0] exp_v;
        int says;
        int cyc;
        int first_rdy;
        bit finished;
        says = 0;
        first_rdy = -1;
        finished = 1'b0;

        @(negedge CLK);
        tests_run++;
        if (start__RDY !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s start_rdy: got %b expected 1", name, start__RDY);
        end
        start__ENA = 1'b1;
        start_base = base;
        start_count = count;
        for (int i = 0; i < int'(count); i++) say_q.push_back(base + 32'(i));
        done_q.push_back({exp_to, exp_err});

        @(negedge CLK);
        start__ENA = 1'b0;
        tests_run++;
        if (request_say__ENA !== (count != 16'd0)) begin
            tests_failed++;
            $display("FAIL %s first_say_latency: got ena=%b expected %b", name, request_say__ENA, count != 16'd0);
        end

        cyc = 0;
        while (!finished && cyc < 4 * TIMEOUT + 200) begin
            if (cyc > 0) @(negedge CLK);
            if (indication_heard__RDY && first_rdy < 0) first_rdy = cyc;
            if (done__ENA) begin
                request_say__RDY = 1'b0;
                indication_heard__ENA = 1'b0;
                done__RDY = 1'b0;
                exp_done = done_q.pop_front();
                got_done = {done_timeout, done_errors};
                tests_run++;
                if (got_done !== exp_done) begin
                    tests_failed++;
                    $display("FAIL %s done_report: got to=%b err=%0d expected to=%b err=%0d",
                             name, got_done[16], got_done[15:0], exp_done[16], exp_done[15:0]);
                end
                tests_run++;
                if (says != exp_says) begin
                    tests_failed++;
                    $display("FAIL %s say_count: got %0d expected %0d", name, says, exp_says);
                end
                if (mode == M_HOLD) begin
                    tests_run++;
                    if (cyc - first_rdy != TIMEOUT) begin
                        tests_failed++;
                        $display("FAIL %s timeout_delay: got %0d expected %0d", name, cyc - first_rdy, TIMEOUT);
                    end
                end
                if (count == 16'd0) begin
                    tests_run++;
                    if (cyc != 0) begin
                        tests_failed++;
                        $display("FAIL %s zero_count_latency: got %0d expected 0", name, cyc);
                    end
                end
                // Report must hold while the host withholds done__RDY.
                @(negedge CLK);
                tests_run++;
                if ({done__ENA, done_timeout, done_errors} !== {1'b1, exp_done}) begin
                    tests_failed++;
                    $display("FAIL %s done_hold: got ena=%b to=%b err=%0d expected ena=1 to=%b err=%0d",
                             name, done__ENA, done_timeout, done_errors, exp_done[16], exp_done[15:0]);
                end
                done__RDY = 1'b1;
                @(negedge CLK);
                done__RDY = 1'b0;
                tests_run++;
                if ({start__RDY, done__ENA, indication_heard__RDY} !== 3'b100) begin
                    tests_failed++;
                    $display("FAIL %s back_to_idle: got rdy=%b done=%b hrdy=%b expected 1 0 0",
                             name, start__RDY, done__ENA, indication_heard__RDY);
                end
                finished = 1'b1;
            end else begin
                request_say__RDY = (mode == M_ECHO) ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (request_say__ENA && request_say__RDY) begin
                    says++;
                    tests_run++;
                    if (say_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL %s say_value: got unexpected say %h expected none", name, request_say_v);
                    end else begin
                        exp_v = say_q.pop_front();
                        if (request_say_v !== exp_v) begin
                            tests_failed++;
                            $display("FAIL %s say_value: got %h expected %h", name, request_say_v, exp_v);
                        end
                    end
                    resp_q.push_back((mode == M_CORRUPT && says == 2) ? request_say_v + 32'd1 : request_say_v);
                end
                if (mode != M_HOLD && resp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    indication_heard__ENA = 1'b1;
                    indication_heard_v = resp_q[0];
                    if (indication_heard__RDY) void'(resp_q.pop_front());
                end else begin
                    indication_heard__ENA = 1'b0;
                end
            end
            cyc++;
        end
        if (!finished) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s no_done: got no done__ENA within %0d cycles expected a report", name, cyc);
            request_say__RDY = 1'b0;
            indication_heard__ENA = 1'b0;
        end
    endtask

    task automatic test_echo();
        run_session(32'd5, 16'd3, M_ECHO, 16'd0, 1'b0, 3, "echo");
    endtask

    task automatic test_mismatch();
        run_session(32'd10, 16'd4, M_CORRUPT, 16'd1, 1'b0, 4, "mismatch");
    endtask

    task automatic test_zero_count();
        run_session(32'd77, 16'd0, M_ECHO, 16'd0, 1'b0, 0, "zero_count");
    endtask

    task automatic test_wrap();
        run_session(32'hFFFF_FFFE, 16'd3, M_ECHO, 16'd0, 1'b0, 3, "wrap");
    endtask

    task automatic test_timeout();
        run_session(32'd100, 16'd8, M_HOLD, 16'd0, 1'b1, DEPTH, "timeout");
    endtask

    task automatic test_back_to_back();
        run_session(32'd200, 16'd20, M_ECHO, 16'd0, 1'b0, 20, "b2b_a");
        run_session(32'h1234_0000, 16'd1, M_ECHO, 16'd0, 1'b0, 1, "b2b_b");
    endtask

    task automatic test_reset_mid_run();
        int says;
        int guard;
        bit saw_done;
        says = 0;
        guard = 0;
        saw_done = 1'b0;
        @(negedge CLK);
        start__ENA = 1'b1;
        start_base = 32'd300;
        start_count = 16'd10;
        @(negedge CLK);
        start__ENA = 1'b0;
        indication_heard__ENA = 1'b0;
        request_say__RDY = 1'b1;
        while (says < 2 && guard < 20) begin
            if (request_say__ENA) says++;
            guard++;
            @(negedge CLK);
        end
        request_say__RDY = 1'b0;
        tests_run++;
        if ({indication_heard__RDY, says == 2} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_mid_run outstanding: got hrdy=%b says=%0d expected hrdy=1 says=2",
                     indication_heard__RDY, says);
        end
        nRST = 1'b0;
        @(negedge CLK);
        tests_run++;
        if ({start__RDY, request_say__ENA, request_say_v, indication_heard__RDY,
             done__ENA, done_errors, done_timeout} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_run outputs: got rdy=%b say=%b v=%h hrdy=%b done=%b err=%h to=%b, expected rdy=1 others 0",
                     start__RDY, request_say__ENA, request_say_v, indication_heard__RDY,
                     done__ENA, done_errors, done_timeout);
        end
        nRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (done__ENA || !start__RDY) saw_done = 1'b1;
        end
        tests_run++;
        if (saw_done) begin
            tests_failed++;
            $display("FAIL reset_mid_run abandon: got done/busy after reset expected idle with no report");
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_mismatch();
        test_zero_count();
        test_wrap();
        test_timeout();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/example1_driver.md
EXAMPLE1_DRIVER -- requirements
Module: example1_driver

Interface
REQ-001 SHALL have parameter DEPTH, 4, the maximum number of outstanding say requests (scoreboard depth, power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, 1024, the number of cycles without a heard response that aborts a run.
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 nRST  input  1  reset; synchronous and active-low.
REQ-005 start__ENA  input  1  host starts a run.
REQ-006 start$base  input  32  first value to send.
REQ-007 start$count  input  16  number of say requests in the run.
REQ-008 start__RDY  output  1  driver idle and able to accept start.
REQ-009 request$say__ENA  output  1  say request valid.
REQ-010 request$say$v  output  32  say value.
REQ-011 request$say__RDY  input  1  responder can accept say.
REQ-012 indication$heard__ENA  input  1  responder delivers a heard value.
REQ-013 indication$heard$v  input  32  heard value.
REQ-014 indication$heard__RDY  output  1  driver can accept heard.
REQ-015 done__ENA  output  1  run-complete report valid.
REQ-016 done$errors  output  16  mismatch count of the run.
REQ-017 done$timeout  output  1  run aborted by watchdog.
REQ-018 done__RDY  input  1  host accepts report.

Function
REQ-019 A transfer on any method SHALL occur in a cycle where its __ENA and __RDY are both 1.
REQ-020 The FSM SHALL have states IDLE, ISSUE, DRAIN, REPORT; start__RDY SHALL be 1 exactly in IDLE.
REQ-021 On a start transfer: next_v<=start$base, remaining<=start$count, errors<=0, timeout flag<=0; next state ISSUE, or REPORT if start$count==0.
REQ-022 request$say__ENA SHALL be 1 iff state==ISSUE, remaining!=0, and scoreboard occupancy<DEPTH; request$say$v SHALL equal next_v.
REQ-023 On a say transfer: push next_v to the scoreboard, next_v<=next_v+1 (mod 2^32, 0xFFFFFFFF wraps to 0), remaining<=remaining-1.
REQ-024 When the say transfer takes remaining to 0, the next state SHALL be DRAIN.
REQ-025 indication$heard__RDY SHALL be 1 iff state is ISSUE or DRAIN and the scoreboard is non-empty; heard never fires when the scoreboard is empty.
REQ-026 On a heard transfer: pop the head; if indication$heard$v!=head, errors<=errors+1, saturating at 0xFFFF.
REQ-027 Push and pop in the same cycle SHALL both take effect; occupancy is unchanged. A push is gated only by occupancy before the cycle (full blocks a push even if a pop occurs).
REQ-028 DRAIN SHALL go to REPORT in the cycle after the scoreboard becomes empty.
REQ-029 The watchdog SHALL count cycles in ISSUE/DRAIN while the scoreboard is non-empty and no heard transfer occurs. It SHALL clear on any heard transfer or when the scoreboard is empty.
REQ-030 When the watchdog reaches TIMEOUT-1, the timeout flag SHALL set and the next state SHALL be REPORT regardless of remaining or occupancy.
REQ-031 In REPORT, done__ENA=1 with done$errors=errors and done$timeout=flag, held stable until a done transfer. On the transfer: flush the scoreboard and go to IDLE.
REQ-032 Latency: first request$say__ENA SHALL assert in the cycle after the start transfer.

Reset
REQ-033 While nRST=0 at a clock edge: state<=IDLE, scoreboard empty, next_v, remaining, errors, watchdog and timeout flag <=0.
REQ-034 After reset: start__RDY=1, request$say__ENA=0, request$say$v=0, indication$heard__RDY=0, done__ENA=0, done$errors=0, done$timeout=0.
REQ-035 Reset mid-run SHALL abandon the run with no done report.

Structure
REQ-036 Shared package example1_pkg SHALL hold the FSM state enum, DEPTH and TIMEOUT defaults, and the value width (32).
REQ-037 The scoreboard SHALL be sub-module example1_scoreboard_fifo: DEPTH x 32 synchronous FIFO with push, pop, full, empty and head outputs, wrapping pointers, and an occupancy counter.

Verification
REQ-038 Paired with the Example1 responder: base=5, count=3 -> says 5,6,7; heard 5,6,7; done errors=0, timeout=0.
REQ-039 Model responder returns v+1 for the second value: base=10, count=4 -> done errors=1, timeout=0.
REQ-040 count=0 -> no say issued; done__ENA one cycle after start, errors=0; start__RDY=1 after the done transfer.
REQ-041 Responder holds heard off, DEPTH=4, count=8 -> exactly 4 says issued, then stall; TIMEOUT cycles later done timeout=1.
REQ-042 base=0xFFFFFFFE, count=3 with echo responder -> says 0xFFFFFFFE, 0xFFFFFFFF, 0x0; errors=0.
REQ-043 nRST pulsed low during ISSUE with 2 outstanding -> all outputs at reset values next cycle; no done__ENA.
